// File: rtl/dig_clock_param.sv
// Parameterised 24-hour time-of-day clock with 12/24-hour display,
// validated time load and a sticky minute-resolution alarm.
module dig_clock_param #(
    parameter int TICKS_PER_SEC    = 100000000,
    parameter bit ALARM_EN_DEFAULT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       load,
    input  logic [4:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    input  logic [4:0] alarm_h,
    input  logic [5:0] alarm_m,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       alarm,
    output logic       load_err
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    h_q, h_d;
    logic [5:0]    m_q, m_d;
    logic [5:0]    s_q, s_d;
    logic          sec_tick_q, sec_tick_d;
    logic          alarm_q, alarm_d;
    logic          load_err_q, load_err_d;

    logic tick_now;
    logic load_ok;
    logic advance;
    logic alarm_ok;
    logic alarm_match;
    logic alarm_clear;

    always_comb begin
        presc_d    = presc_q;
        h_d        = h_q;
        m_d        = m_q;
        s_d        = s_q;
        sec_tick_d = 1'b0;
        alarm_d    = alarm_q;
        load_err_d = 1'b0;

        tick_now = (presc_q == PRESC_MAX);
        load_ok  = load && (load_h <= 5'd23) &&
                   (load_m <= 6'd59) && (load_s <= 6'd59);
        // A valid load owns the cycle; the pending second is dropped.
        advance  = tick_now && !load_ok;
        alarm_ok = (alarm_h <= 5'd23) && (alarm_m <= 6'd59);
        // Reserved parameter is referenced but inert.
        alarm_clear = alarm_ack || !alarm_en ||
                      (ALARM_EN_DEFAULT && 1'b0);

        if (load_ok) begin
            h_d     = load_h;
            m_d     = load_m;
            s_d     = load_s;
            presc_d = '0;
        end else begin
            presc_d = tick_now ? '0 : presc_q + PW'(1);
            if (advance) begin
                if (s_q == 6'd59) begin
                    s_d = 6'd0;
                    if (m_q == 6'd59) begin
                        m_d = 6'd0;
                        h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
                    end else begin
                        m_d = m_q + 6'd1;
                    end
                end else begin
                    s_d = s_q + 6'd1;
                end
            end
        end

        sec_tick_d  = advance;
        load_err_d  = load && !load_ok;
        alarm_match = advance && alarm_en && alarm_ok &&
                      (h_d == alarm_h) && (m_d == alarm_m) &&
                      (s_d == 6'd0);

        if (alarm_match) begin
            alarm_d = 1'b1;
        end else if (alarm_clear) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            h_q        <= 5'd0;
            m_q        <= 6'd0;
            s_q        <= 6'd0;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            h_q        <= h_d;
            m_q        <= m_d;
            s_q        <= s_d;
            sec_tick_q <= sec_tick_d;
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        hours = h_q;
        if (mode) begin
            if (h_q == 5'd0) begin
                hours = 5'd12;
            end else if (h_q > 5'd12) begin
                hours = h_q - 5'd12;
            end
        end
    end

    assign pm       = (h_q >= 5'd12);
    assign seconds  = s_q;
    assign minutes  = m_q;
    assign sec_tick = sec_tick_q;
    assign alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_dig_clock_param.sv
// Bench for dig_clock_param: directed scenarios plus random traffic,
// checked against a seconds-of-day reference model.
module tb_dig_clock_param;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       load;
    logic [4:0] load_h;
    logic [5:0] load_m;
    logic [5:0] load_s;
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic       alarm_en;
    logic       alarm_ack;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic       sec_tick;
    logic       alarm;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds since midnight.
    int tod   = 0;
    int phase = 0;
    int m_tick  = 0;
    int m_alarm = 0;
    int m_err   = 0;

    dig_clock_param #(.TICKS_PER_SEC(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .load      (load),
        .load_h    (load_h),
        .load_m    (load_m),
        .load_s    (load_s),
        .alarm_h   (alarm_h),
        .alarm_m   (alarm_m),
        .alarm_en  (alarm_en),
        .alarm_ack (alarm_ack),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .pm        (pm),
        .sec_tick  (sec_tick),
        .alarm     (alarm),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_next();
        int valid;
        int hit;
        if (reset) begin
            tod = 0; phase = 0; m_tick = 0; m_alarm = 0; m_err = 0;
        end else begin
            valid = (load && load_h < 24 && load_m < 60 && load_s < 60) ? 1 : 0;
            m_err = (load && !valid) ? 1 : 0;
            if (valid != 0) begin
                tod = int'(load_h) * 3600 + int'(load_m) * 60 + int'(load_s);
                phase = 0;
                m_tick = 0;
            end else begin
                m_tick = (phase == T - 1) ? 1 : 0;
                phase = (phase + 1) % T;
                if (m_tick != 0) tod = (tod + 1) % 86400;
            end
            hit = (m_tick != 0 && alarm_en && alarm_h < 24 && alarm_m < 60 &&
                   tod == int'(alarm_h) * 3600 + int'(alarm_m) * 60) ? 1 : 0;
            if (hit != 0) m_alarm = 1;
            else if (alarm_ack || !alarm_en) m_alarm = 0;
        end
    endtask

    task automatic check_all();
        int h;
        h = tod / 3600;
        chk("seconds", 32'(seconds), 32'(tod % 60));
        chk("minutes", 32'(minutes), 32'((tod / 60) % 60));
        chk("hours", 32'(hours), mode ? 32'((h + 11) % 12 + 1) : 32'(h));
        chk("pm", 32'(pm), 32'(h >= 12));
        chk("sec_tick", 32'(sec_tick), 32'(m_tick));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("load_err", 32'(load_err), 32'(m_err));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1'b1;
        load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
        step();
        load = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (m_tick == 0 && k < 2 * T);
        chk(tag, 32'(sec_tick), 32'd1);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; load = 1'b0;
        load_h = '0; load_m = '0; load_s = '0;
        alarm_h = 5'd31; alarm_m = '0; alarm_en = 1'b0; alarm_ack = 1'b0;
        #1;
        step();
        step();
        chk("rst_hours24", 32'(hours), 32'd0);
        mode = 1'b1; #1;
        chk("rst_hours12", 32'(hours), 32'd12);
        mode = 1'b0;

        // First second after reset release.
        reset = 1'b0;
        repeat (3) step();
        chk("pre_tick", 32'(sec_tick), 32'd0);
        step();
        chk("first_tick", 32'(sec_tick), 32'd1);
        chk("first_sec", 32'(seconds), 32'd1);
        repeat (4) step();
        chk("second_tick", 32'(sec_tick), 32'd1);

        // Midnight rollover.
        do_load(23, 59, 58);
        chk("ld_pm", 32'(pm), 32'd1);
        repeat (4) step();
        chk("roll_s59", 32'(seconds), 32'd59);
        chk("roll_h23", 32'(hours), 32'd23);
        repeat (4) step();
        chk("roll_h0", 32'(hours), 32'd0);
        chk("roll_m0", 32'(minutes), 32'd0);
        chk("roll_pm0", 32'(pm), 32'd0);

        // Mode switch is combinational.
        do_load(13, 5, 0);
        chk("m24_hours", 32'(hours), 32'd13);
        mode = 1'b1; #1;
        chk("m12_hours", 32'(hours), 32'd1);
        chk("m12_pm", 32'(pm), 32'd1);
        chk("m12_min", 32'(minutes), 32'd5);
        step();

        // Invalid load.
        do_load(24, 10, 10);
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_min", 32'(minutes), 32'd5);
        step();
        chk("bad_err_clr", 32'(load_err), 32'd0);

        // Load on a tick cycle.
        for (int k = 0; k < T && phase != T - 1; k++) step();
        chk("phase_ready", 32'(phase), 32'(T - 1));
        do_load(10, 20, 30);
        chk("lt_sec", 32'(seconds), 32'd30);
        chk("lt_notick", 32'(sec_tick), 32'd0);
        repeat (3) step();
        step();
        chk("lt_tick4", 32'(sec_tick), 32'd1);
        chk("lt_sec31", 32'(seconds), 32'd31);

        // Alarm set, hold, ack, reset.
        mode = 1'b0;
        alarm_h = 5'd7; alarm_m = 6'd30; alarm_en = 1'b1;
        do_load(7, 30, 0);
        chk("al_noload", 32'(alarm), 32'd0);
        do_load(7, 29, 59);
        wait_tick("al_tick");
        chk("al_set", 32'(alarm), 32'd1);
        repeat (5) step();
        chk("al_held", 32'(alarm), 32'd1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("al_ack", 32'(alarm), 32'd0);
        do_load(7, 29, 59);
        wait_tick("al_tick2");
        chk("al_set2", 32'(alarm), 32'd1);
        reset = 1'b1;
        step();
        chk("al_rst", 32'(alarm), 32'd0);
        chk("rst_sec", 32'(seconds), 32'd0);
        chk("rst_tick", 32'(sec_tick), 32'd0);
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            mode = 1'($urandom);
            alarm_ack = ($urandom_range(0, 19) == 0);
            alarm_en = ($urandom_range(0, 7) != 0);
            if (i % 40 == 0) begin
                alarm_h = 5'($urandom_range(0, 23));
                alarm_m = 6'($urandom_range(1, 59));
                alarm_en = 1'b1;
                alarm_ack = 1'b0;
                load = 1'b1;
                load_h = alarm_h;
                load_m = alarm_m - 6'd1;
                load_s = 6'd59;
            end else begin
                load = ($urandom_range(0, 15) == 0);
                load_h = 5'($urandom_range(0, 31));
                load_m = 6'($urandom_range(0, 63));
                load_s = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) begin
                    alarm_h = 5'($urandom_range(0, 31));
                    alarm_m = 6'($urandom_range(0, 63));
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
